// File: rtl/score_keeper.sv
// Score keeper: turns line-clear results into a BCD score, a saturating line
// count, a level and the matching gravity period for the drop timer.
module score_keeper (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_valid,
  input  logic [3:0]  score_plus,
  output logic        clear_ready,
  input  logic        game_restart,
  output logic [15:0] score_bcd,
  output logic [9:0]  lines_total,
  output logic [3:0]  level,
  output logic [5:0]  drop_ticks,
  output logic        update_done
);

  typedef enum logic [1:0] {IDLE, ADD, UPD} state_t;

  state_t      state;
  logic [2:0]  n_lines;
  logic [3:0]  pts;
  logic [3:0]  rep;
  logic [3:0]  sub_cnt;

  logic [2:0]  n_in;
  logic [3:0]  pts_in;
  logic [10:0] lines_sum;
  logic [4:0]  sub_sum;
  logic [3:0]  level_next;
  logic [3:0]  sub_next;

  // Decimal add of p to a 4-digit BCD value; a carry out of the top digit
  // means the true sum is above 9999, so the result pins at 9999.
  function automatic logic [15:0] bcd_add(input logic [15:0] s, input logic [3:0] p);
    logic [15:0] r;
    logic [4:0]  d;
    logic [3:0]  c;
    r = '0;
    c = p;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, s[i*4 +: 4]} + {1'b0, c};
      if (d > 5'd9) begin
        r[i*4 +: 4] = 4'(d - 5'd10);
        c = 4'd1;
      end else begin
        r[i*4 +: 4] = d[3:0];
        c = 4'd0;
      end
    end
    if (c != 4'd0) r = 16'h9999;
    return r;
  endfunction

  assign clear_ready = (state == IDLE);

  always_comb begin
    n_in       = (score_plus > 4'd4) ? 3'd4 : score_plus[2:0];
    pts_in     = 4'd8;
    lines_sum  = {1'b0, lines_total} + 11'(n_lines);
    sub_sum    = {1'b0, sub_cnt} + 5'(n_lines);
    level_next = level;
    sub_next   = sub_sum[3:0];
    case (n_in)
      3'd1:    pts_in = 4'd1;
      3'd2:    pts_in = 4'd3;
      3'd3:    pts_in = 4'd5;
      default: pts_in = 4'd8;
    endcase
    if (sub_sum >= 5'd10) begin
      sub_next = 4'(sub_sum - 5'd10);
      if (level != 4'd9) level_next = level + 4'd1;
    end
  end

  // Restart outranks everything, including an operation already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      n_lines     <= '0;
      pts         <= '0;
      rep         <= '0;
      sub_cnt     <= '0;
      score_bcd   <= '0;
      lines_total <= '0;
      level       <= '0;
      drop_ticks  <= 6'd48;
      update_done <= 1'b0;
    end else if (game_restart) begin
      state       <= IDLE;
      n_lines     <= '0;
      pts         <= '0;
      rep         <= '0;
      sub_cnt     <= '0;
      score_bcd   <= '0;
      lines_total <= '0;
      level       <= '0;
      drop_ticks  <= 6'd48;
      update_done <= 1'b0;
    end else begin
      update_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_valid && n_in != 3'd0) begin
            n_lines <= n_in;
            pts     <= pts_in;
            rep     <= level + 4'd1;
            state   <= ADD;
          end
        end
        ADD: begin
          score_bcd <= bcd_add(score_bcd, pts);
          rep       <= rep - 4'd1;
          if (rep == 4'd1) state <= UPD;
        end
        UPD: begin
          lines_total <= (lines_sum > 11'd999) ? 10'd999 : lines_sum[9:0];
          sub_cnt     <= sub_next;
          level       <= level_next;
          drop_ticks  <= 6'd48 - {level_next, 2'b00};
          update_done <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: stimulus pushes expected results,
// a monitor pops and compares them on every update_done pulse.
module tb_score_keeper;

  logic        clk;
  logic        rst_n;
  logic        clear_valid;
  logic [3:0]  score_plus;
  logic        clear_ready;
  logic        game_restart;
  logic [15:0] score_bcd;
  logic [9:0]  lines_total;
  logic [3:0]  level;
  logic [5:0]  drop_ticks;
  logic        update_done;

  typedef struct {
    logic [15:0] score;
    logic [9:0]  lines;
    logic [3:0]  lvl;
    logic [5:0]  drop;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   done_count = 0;

  // Reference state kept as plain integers.
  int m_score = 0;
  int m_lines = 0;
  int m_level = 0;
  int m_sub   = 0;

  score_keeper dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_valid  (clear_valid),
    .score_plus   (score_plus),
    .clear_ready  (clear_ready),
    .game_restart (game_restart),
    .score_bcd    (score_bcd),
    .lines_total  (lines_total),
    .level        (level),
    .drop_ticks   (drop_ticks),
    .update_done  (update_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ready"}, int'(clear_ready), 1);
    checkOutput({tag, "_score"}, int'(score_bcd), 0);
    checkOutput({tag, "_lines"}, int'(lines_total), 0);
    checkOutput({tag, "_level"}, int'(level), 0);
    checkOutput({tag, "_drop"}, int'(drop_ticks), 48);
    checkOutput({tag, "_done"}, int'(update_done), 0);
  endtask

  task automatic modelReset();
    m_score = 0;
    m_lines = 0;
    m_level = 0;
    m_sub   = 0;
  endtask

  task automatic modelApply(input logic [3:0] sp);
    int   n;
    int   p;
    exp_t e;
    n = (sp > 4) ? 4 : int'(sp);
    if (n == 0) return;
    p = (n == 1) ? 1 : (n == 2) ? 3 : (n == 3) ? 5 : 8;
    m_score = m_score + p * (m_level + 1);
    if (m_score > 9999) m_score = 9999;
    m_lines = m_lines + n;
    if (m_lines > 999) m_lines = 999;
    m_sub = m_sub + n;
    if (m_sub >= 10) begin
      m_sub = m_sub - 10;
      if (m_level < 9) m_level++;
    end
    e.score = to_bcd(m_score);
    e.lines = 10'(m_lines);
    e.lvl   = 4'(m_level);
    e.drop  = 6'(48 - 4 * m_level);
    exp_q.push_back(e);
  endtask

  // Offers one result at a negedge and measures how long clear_ready stays low.
  task automatic applyStimulus(input logic [3:0] sp);
    int busy;
    int lat_exp;
    lat_exp = (sp == 4'd0) ? 0 : m_level + 2;
    modelApply(sp);
    clear_valid = 1'b1;
    score_plus  = sp;
    @(negedge clk);
    clear_valid = 1'b0;
    score_plus  = 4'd0;
    busy = 0;
    while (!clear_ready && busy < 40) begin
      busy++;
      @(negedge clk);
    end
    checkOutput("latency", busy, lat_exp);
  endtask

  task automatic restartGame();
    game_restart = 1'b1;
    @(negedge clk);
    game_restart = 1'b0;
    modelReset();
    checkReset("restart");
  endtask

  always @(negedge clk) begin
    if (rst_n && update_done) begin
      exp_t e;
      done_count++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_score", int'(score_bcd), int'(e.score));
        checkOutput("sb_lines", int'(lines_total), int'(e.lines));
        checkOutput("sb_level", int'(level), int'(e.lvl));
        checkOutput("sb_drop", int'(drop_ticks), int'(e.drop));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dc;
    rst_n        = 1'b0;
    clear_valid  = 1'b0;
    score_plus   = 4'd0;
    game_restart = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("por");
    rst_n = 1'b1;

    // Four-line clear straight out of reset.
    applyStimulus(4'd4);
    checkOutput("v1_score", int'(score_bcd), 16'h0008);
    checkOutput("v1_lines", int'(lines_total), 4);
    checkOutput("v1_level", int'(level), 0);

    // Ten singles reach level 1, then a double adds 3 twice.
    restartGame();
    for (int i = 0; i < 10; i++) applyStimulus(4'd1);
    checkOutput("v2_level", int'(level), 1);
    checkOutput("v2_drop", int'(drop_ticks), 44);
    applyStimulus(4'd2);
    checkOutput("v2_score", int'(score_bcd), 16'h0016);
    checkOutput("v2_lines", int'(lines_total), 12);

    // Zero lines changes nothing; seven lines counts as four.
    restartGame();
    applyStimulus(4'd1);
    @(negedge clk);
    dc = done_count;
    applyStimulus(4'd0);
    repeat (3) @(negedge clk);
    checkOutput("zero_done", done_count, dc);
    checkOutput("zero_score", int'(score_bcd), 16'h0001);
    checkOutput("zero_lines", int'(lines_total), 1);
    applyStimulus(4'd7);
    checkOutput("seven_score", int'(score_bcd), 16'h0009);
    checkOutput("seven_lines", int'(lines_total), 5);

    // Restart in the middle of a multi-cycle ADD with the result still offered.
    applyStimulus(4'd4);
    applyStimulus(4'd4);
    checkOutput("pre_abort_level", int'(level), 1);
    @(negedge clk);
    dc = done_count;
    clear_valid = 1'b1;
    score_plus  = 4'd3;
    @(negedge clk);
    checkOutput("abort_busy", int'(clear_ready), 0);
    game_restart = 1'b1;
    @(negedge clk);
    checkReset("abort_add");
    game_restart = 1'b0;
    clear_valid  = 1'b0;
    score_plus   = 4'd0;
    modelReset();
    repeat (6) @(negedge clk);
    checkOutput("abort_no_done", done_count, dc);
    checkOutput("abort_no_add", int'(score_bcd), 0);

    // Asynchronous reset while in UPD.
    applyStimulus(4'd1);
    @(negedge clk);
    dc = done_count;
    clear_valid = 1'b1;
    score_plus  = 4'd1;
    @(negedge clk);
    clear_valid = 1'b0;
    score_plus  = 4'd0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkReset("rst_upd");
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    repeat (6) @(negedge clk);
    checkOutput("rst_no_done", done_count, dc);
    checkOutput("rst_no_add", int'(score_bcd), 0);

    // Long run of tetrises: carries across digit boundaries, level cap,
    // score saturation and line-count saturation.
    for (int i = 0; i < 260; i++) applyStimulus(4'd4);
    checkOutput("sat_score", int'(score_bcd), 16'h9999);
    checkOutput("sat_lines", int'(lines_total), 999);
    checkOutput("sat_level", int'(level), 9);
    checkOutput("sat_drop", int'(drop_ticks), 12);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
